// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: framed UART command sequencer driving the register file and ALU.
// Commands (first byte in IDLE): AA addr,data = write; BB addr = read;
// CC A,B,fun = load reg0/reg1 then run ALU; DD fun = run ALU on current regs.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   rx_data_in / rx_valid_in          received byte and its 1-cycle valid
//   rf_rd_data_in / rf_rd_valid_in    register-file read return
//   alu_out_in / alu_valid_in         ALU result return (2*DATA_WIDTH)
//   tx_busy_in                        transmitter busy
//   rf_addr_out, rf_wr_en_out, rf_rd_en_out, rf_wr_data_out   register-file access
//   alu_fun_out, alu_en_out           ALU function and start strobe
//   tx_data_out / tx_valid_out        byte to transmit and its 1-cycle valid
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   rx_data_in,
  input  logic                    rx_valid_in,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data_in,
  input  logic                    rf_rd_valid_in,
  input  logic [2*DATA_WIDTH-1:0] alu_out_in,
  input  logic                    alu_valid_in,
  input  logic                    tx_busy_in,
  output logic [ADDR_WIDTH-1:0]   rf_addr_out,
  output logic                    rf_wr_en_out,
  output logic                    rf_rd_en_out,
  output logic [DATA_WIDTH-1:0]   rf_wr_data_out,
  output logic [FUN_WIDTH-1:0]    alu_fun_out,
  output logic                    alu_en_out,
  output logic [DATA_WIDTH-1:0]   tx_data_out,
  output logic                    tx_valid_out
);
  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI
  } state_e;
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    is_alu_q, is_alu_d;
  logic                    seen_q, seen_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic                    rf_wr_en_q, rf_wr_en_d;
  logic                    rf_rd_en_q, rf_rd_en_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
  logic                    alu_en_q, alu_en_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    res_d        = res_q;
    is_alu_d     = is_alu_q;
    seen_d       = seen_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    alu_en_d     = 1'b0;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;
    case (state_q)
      IDLE:
        if (rx_valid_in)
          state_d = rx_data_in == CMD_WR  ? WR_ADDR :
                    rx_data_in == CMD_RD  ? RD_ADDR :
                    rx_data_in == CMD_ALU ? OP_A    :
                    rx_data_in == CMD_FUN ? ALU_FUN : IDLE;
      WR_ADDR:
        if (rx_valid_in) begin
          addr_d  = rx_data_in[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
      WR_DATA:
        if (rx_valid_in) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = addr_q;
          rf_wr_data_d = rx_data_in;
          state_d      = IDLE;
        end
      RD_ADDR:
        if (rx_valid_in) begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = rx_data_in[ADDR_WIDTH-1:0];
          state_d    = RD_WAIT;
        end
      RD_WAIT:
        if (rf_rd_valid_in) begin
          res_d    = {{DATA_WIDTH{1'b0}}, rf_rd_data_in};
          is_alu_d = 1'b0;
          state_d  = TX_LO;
        end
      OP_A:
        if (rx_valid_in) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR_WIDTH'(0);
          rf_wr_data_d = rx_data_in;
          state_d      = OP_B;
        end
      OP_B:
        if (rx_valid_in) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR_WIDTH'(1);
          rf_wr_data_d = rx_data_in;
          state_d      = ALU_FUN;
        end
      ALU_FUN:
        if (rx_valid_in) begin
          alu_fun_d = rx_data_in[FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          state_d   = ALU_WAIT;
        end
      ALU_WAIT:
        if (alu_valid_in) begin
          res_d    = alu_out_in;
          is_alu_d = 1'b1;
          state_d  = TX_LO;
        end
      TX_LO:
        if (!tx_busy_in) begin
          tx_valid_d = 1'b1;
          tx_data_d  = res_q[DATA_WIDTH-1:0];
          seen_d     = 1'b0;
          state_d    = is_alu_q ? TX_HI : IDLE;
        end
      // High byte waits for the transmitter to take the low byte (busy rises) and finish it (busy falls).
      TX_HI:
        if (tx_busy_in) seen_d = 1'b1;
        else if (seen_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d    = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      res_q          <= '0;
      is_alu_q       <= 1'b0;
      seen_q         <= 1'b0;
      rf_addr_q      <= '0;
      rf_wr_en_q     <= 1'b0;
      rf_rd_en_q     <= 1'b0;
      rf_wr_data_q   <= '0;
      alu_fun_q      <= '0;
      alu_en_q       <= 1'b0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      res_q          <= res_d;
      is_alu_q       <= is_alu_d;
      seen_q         <= seen_d;
      rf_addr_q      <= rf_addr_d;
      rf_wr_en_q     <= rf_wr_en_d;
      rf_rd_en_q     <= rf_rd_en_d;
      rf_wr_data_q   <= rf_wr_data_d;
      alu_fun_q      <= alu_fun_d;
      alu_en_q       <= alu_en_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
    end
  end
  assign rf_addr_out    = rf_addr_q;
  assign rf_wr_en_out   = rf_wr_en_q;
  assign rf_rd_en_out   = rf_rd_en_q;
  assign rf_wr_data_out = rf_wr_data_q;
  assign alu_fun_out    = alu_fun_q;
  assign alu_en_out     = alu_en_q;
  assign tx_data_out    = tx_data_q;
  assign tx_valid_out   = tx_valid_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed bench with a protocol-level model for uart_cmd_ctrl.
module tb_uart_cmd_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data_in = '0;
  logic        rx_valid_in = 1'b0;
  logic [7:0]  rf_rd_data_in = '0;
  logic        rf_rd_valid_in = 1'b0;
  logic [15:0] alu_out_in = '0;
  logic        alu_valid_in = 1'b0;
  logic        tx_busy_in = 1'b0;
  logic [3:0]  rf_addr_out;
  logic        rf_wr_en_out;
  logic        rf_rd_en_out;
  logic [7:0]  rf_wr_data_out;
  logic [3:0]  alu_fun_out;
  logic        alu_en_out;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;

  uart_cmd_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in),
    .rf_rd_data_in(rf_rd_data_in), .rf_rd_valid_in(rf_rd_valid_in),
    .alu_out_in(alu_out_in), .alu_valid_in(alu_valid_in),
    .tx_busy_in(tx_busy_in),
    .rf_addr_out(rf_addr_out), .rf_wr_en_out(rf_wr_en_out), .rf_rd_en_out(rf_rd_en_out),
    .rf_wr_data_out(rf_wr_data_out), .alu_fun_out(alu_fun_out), .alu_en_out(alu_en_out),
    .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {logic [3:0] addr; logic [7:0] data; int cyc;} ev_t;
  typedef struct {logic [7:0] data; bit hi;} tx_t;
  ev_t        wq[$], rq[$], aq[$];
  tx_t        tq[$];
  logic [7:0] pend[$];
  logic [7:0] tx_log[$];
  logic [11:0] w_log[$];
  int         checks = 0, errors = 0, cyc = 0, busy_cnt = 0;
  logic [3:0] last_addr = '0, last_fun = '0;
  logic [7:0] last_data = '0;
  bit         seen_busy = 0, busy_force = 0;
  ev_t        e;
  tx_t        t;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endfunction

  function automatic void flag(string n, bit got);
    checks++;
    errors++;
    $display("FAIL %s: got event=%0b required event=%0b", n, got, !got);
  endfunction

  // Protocol model: collect a command's bytes and emit the strobes each byte must cause,
  // stamped with the cycle in which the strobe must be visible.
  function automatic void model_byte(logic [7:0] b, int c);
    int need;
    if (pend.size() == 0 && !(b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD})) return;
    pend.push_back(b);
    need = 2;
    case (pend[0])
      8'hAA: begin need = 3; if (pend.size() == 3) wq.push_back('{pend[1][3:0], b, c}); end
      8'hBB: if (pend.size() == 2) rq.push_back('{b[3:0], 8'h00, c});
      8'hCC: begin
        need = 4;
        if (pend.size() == 2) wq.push_back('{4'd0, b, c});
        else if (pend.size() == 3) wq.push_back('{4'd1, b, c});
        else if (pend.size() == 4) aq.push_back('{b[3:0], 8'h00, c});
      end
      default: if (pend.size() == 2) aq.push_back('{b[3:0], 8'h00, c});
    endcase
    if (pend.size() == need) pend.delete();
  endfunction

  // Transmitter stand-in: busy for 4 cycles after each accepted byte, or forced high.
  initial forever begin
    @(negedge clk);
    #1;
    if (tx_valid_out) busy_cnt = 4;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy_in = busy_force || busy_cnt > 0;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_outputs", {4'h0, rf_addr_out, rf_wr_en_out, rf_rd_en_out, rf_wr_data_out,
          alu_fun_out, alu_en_out, tx_data_out, tx_valid_out}, 32'h0);
      last_addr = '0; last_data = '0; last_fun = '0; seen_busy = 0;
      pend.delete(); wq.delete(); rq.delete(); aq.delete(); tq.delete();
    end else begin
      if (rf_wr_en_out) begin
        w_log.push_back({rf_addr_out, rf_wr_data_out});
        if (wq.size() == 0) flag("wr_unexpected", 1);
        else begin
          e = wq.pop_front();
          chk("wr_addr", rf_addr_out, e.addr);
          chk("wr_data", rf_wr_data_out, e.data);
          chk("wr_cycle", cyc, e.cyc);
          last_addr = e.addr; last_data = e.data;
        end
      end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
        flag("wr_missing", 0); void'(wq.pop_front());
      end
      if (rf_rd_en_out) begin
        if (rq.size() == 0) flag("rd_unexpected", 1);
        else begin
          e = rq.pop_front();
          chk("rd_addr", rf_addr_out, e.addr);
          chk("rd_cycle", cyc, e.cyc);
          last_addr = e.addr;
        end
      end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
        flag("rd_missing", 0); void'(rq.pop_front());
      end
      if (alu_en_out) begin
        if (aq.size() == 0) flag("alu_unexpected", 1);
        else begin
          e = aq.pop_front();
          chk("alu_fun", alu_fun_out, e.addr);
          chk("alu_cycle", cyc, e.cyc);
          last_fun = e.addr;
        end
      end else if (aq.size() != 0 && aq[0].cyc <= cyc) begin
        flag("alu_missing", 0); void'(aq.pop_front());
      end
      chk("rf_addr_hold", rf_addr_out, last_addr);
      chk("rf_wr_data_hold", rf_wr_data_out, last_data);
      chk("alu_fun_hold", alu_fun_out, last_fun);
      if (tx_valid_out) begin
        chk("tx_while_busy", tx_busy_in, 0);
        tx_log.push_back(tx_data_out);
        if (tq.size() == 0) flag("tx_unexpected", 1);
        else begin
          t = tq.pop_front();
          chk("tx_data", tx_data_out, t.data);
          if (t.hi) chk("tx_hi_after_busy_cycle", seen_busy, 1);
        end
        seen_busy = 0;
      end
      if (tx_busy_in) seen_busy = 1;
    end
  end

  task automatic send(input logic [7:0] b, input bit modeled = 1);
    @(negedge clk);
    rx_data_in = b; rx_valid_in = 1'b1;
    if (modeled) model_byte(b, cyc + 1);
    @(negedge clk);
    rx_valid_in = 1'b0;
  endtask

  task automatic rd_resp(input logic [7:0] d);
    @(negedge clk);
    rf_rd_data_in = d; rf_rd_valid_in = 1'b1;
    tq.push_back('{d, 1'b0});
    @(negedge clk);
    rf_rd_valid_in = 1'b0;
  endtask

  task automatic alu_resp(input logic [15:0] r, input bit modeled = 1);
    @(negedge clk);
    alu_out_in = r; alu_valid_in = 1'b1;
    if (modeled) begin
      tq.push_back('{r[7:0], 1'b0});
      tq.push_back('{r[15:8], 1'b1});
    end
    @(negedge clk);
    alu_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((wq.size() + rq.size() + aq.size() + tq.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) flag("drain_timeout", 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0]  exp_tx [6];
    logic [11:0] exp_w [5];
    exp_tx = '{8'h3C, 8'h30, 8'h00, 8'h34, 8'h12, 8'h5A};
    exp_w  = '{12'h53C, 12'h010, 12'h120, 12'h010, 12'h1FF};
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset_n = 1'b1;
    // Write
    send(8'hAA); send(8'h05); send(8'h3C);
    wait_idle(50);
    // Read, with a stray byte and a stray ALU valid during the wait
    send(8'hBB); send(8'h05);
    send(8'hAA, 0);
    alu_resp(16'hBEEF, 0);
    rd_resp(8'h3C);
    wait_idle(50);
    // ALU with operands
    send(8'hCC); send(8'h10); send(8'h20); send(8'h00);
    repeat (2) @(negedge clk);
    alu_resp(16'h0030);
    wait_idle(100);
    // Dropped byte, then ALU without operands
    send(8'h55); send(8'hDD); send(8'h02);
    repeat (2) @(negedge clk);
    alu_resp(16'h1234);
    wait_idle(100);
    // Stray returns in IDLE must do nothing
    rd_resp(8'h77);
    void'(tq.pop_back());
    alu_resp(16'hFFFF, 0);
    repeat (3) @(negedge clk);
    // Transmitter held busy for 20 cycles in TX_LO
    busy_force = 1;
    send(8'hBB); send(8'h07);
    repeat (2) @(negedge clk);
    rd_resp(8'h5A);
    n = tx_log.size();
    repeat (20) @(negedge clk);
    chk("hold_no_tx", tx_log.size(), n);
    busy_force = 0;
    wait_idle(50);
    chk("hold_one_tx", tx_log.size(), n + 1);
    // Reset in OP_B discards the command
    send(8'hCC); send(8'h10);
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 reset_n = 1'b1;
    send(8'hAA); send(8'h01); send(8'hFF);
    wait_idle(50);
    // Literal pins on the overall traffic
    chk("tx_count", tx_log.size(), 6);
    for (int i = 0; i < 6 && i < tx_log.size(); i++) chk($sformatf("tx_lit%0d", i), tx_log[i], exp_tx[i]);
    chk("wr_count", w_log.size(), 5);
    for (int i = 0; i < 5 && i < w_log.size(); i++) chk($sformatf("wr_lit%0d", i), w_log[i], exp_w[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
